// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with multi-cycle EX tracking
//
// Generates per-stage hold signals for a six-stage pipeline (PC, IF, ID, EX,
// MEM, WB), tracks multi-cycle EX operations with a small FSM, issues the
// IF/ID flush for accepted branches and counts front-end stall cycles.
//
// Optional feature macro: BRANCH_DELAY_SLOT_EN
//   defined   - accepted branches keep the delay-slot instruction; flush_ifid = 0
//   undefined - flush_ifid pulses in each cycle a branch is accepted
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   stallreq_id  in   ID operand hazard, hold PC/IF/ID this cycle
//   ex_mc_start  in   EX starts a multi-cycle operation this cycle
//   ex_mc_cycles in   [4:0] length N of that operation, sampled with ex_mc_start
//   branch_flag  in   ID resolved a taken jump/branch this cycle
//   perf_clr     in   clear stall_cycles
//   stall        out  [5:0] hold per stage, bit0 = PC ... bit5 = WB
//   flush_ifid   out  load a NOP into IF/ID at this edge
//   ex_busy      out  multi-cycle EX operation in progress
//   ex_done      out  pulse in the final cycle of a multi-cycle operation
//   stall_cycles out  [31:0] saturating count of cycles with stall[0] = 1

module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_mc_start,
    input  logic [4:0]  ex_mc_cycles,
    input  logic        branch_flag,
    input  logic        perf_clr,
    output logic [5:0]  stall,
    output logic        flush_ifid,
    output logic        ex_busy,
    output logic        ex_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        IDLE   = 1'b0,
        EXBUSY = 1'b1
    } state_t;

    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_t     state;
    logic [4:0] cnt;

    logic start_ok;
    logic ex_stall;
    logic short_op;

    // A start is only honoured from IDLE; in EXBUSY it is ignored.
    assign start_ok = (state == IDLE) && ex_mc_start;
    // N = 0 and N = 1 complete inside the start cycle without leaving IDLE.
    assign short_op = (ex_mc_cycles <= 5'd1);

    // The start cycle itself is the first stall cycle, so an N-cycle
    // operation stalls for the start cycle plus N-1 EXBUSY cycles.
    assign ex_stall = !rst && ((start_ok && (ex_mc_cycles != 5'd0)) ||
                               (state == EXBUSY));

    always_comb begin
        stall   = STALL_NONE;
        ex_busy = 1'b0;
        ex_done = 1'b0;
        if (!rst) begin
            if (ex_stall) begin
                stall   = STALL_EX;
                ex_busy = 1'b1;
            end else if (stallreq_id) begin
                stall = STALL_ID;
            end
            if (start_ok && short_op) begin
                ex_done = 1'b1;
            end else if ((state == EXBUSY) && (cnt == 5'd0)) begin
                ex_done = 1'b1;
            end
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    assign flush_ifid = 1'b0;
`else
    // While ID is held the branch is re-presented, so it is only taken once
    // ID is free to advance.
    logic branch_accept;
    assign branch_accept = !rst && branch_flag && !stall[2];
    assign flush_ifid    = branch_accept;
`endif

    // cnt holds the number of EXBUSY cycles still to go after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_mc_start && !short_op) begin
                        state <= EXBUSY;
                        cnt   <= ex_mc_cycles - 5'd2;
                    end
                end
                EXBUSY: begin
                    if (cnt == 5'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cycles <= 32'd0;
        end else if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a cycle-count reference model

module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        ex_mc_start;
    logic [4:0]  ex_mc_cycles;
    logic        branch_flag;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush_ifid;
    logic        ex_busy;
    logic        ex_done;
    logic [31:0] stall_cycles;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .branch_flag  (branch_flag),
        .perf_clr     (perf_clr),
        .stall        (stall),
        .flush_ifid   (flush_ifid),
        .ex_busy      (ex_busy),
        .ex_done      (ex_done),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle_no = 0;

    // Reference model: remaining EX-stall cycles after the current one,
    // and the stall counter as an unbounded integer clamped at 2^32-1.
    int      m_rem = 0;
    longint  m_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cycle_no, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle against the model,
    // then advance the model and the clock together.
    task automatic step(input logic r, input logic sid, input logic st, input logic [4:0] n,
                        input logic br, input logic clr);
        logic [5:0] e_stall;
        logic       e_busy, e_done, e_flush, ex_active;
        int         n_int;
        rst = r; stallreq_id = sid; ex_mc_start = st; ex_mc_cycles = n;
        branch_flag = br; perf_clr = clr;
        #2;
        n_int     = int'(n);
        ex_active = 1'b0;
        e_done    = 1'b0;
        if (!r) begin
            if (m_rem > 0) begin
                ex_active = 1'b1;
                e_done    = (m_rem == 1);
            end else if (st) begin
                ex_active = (n_int >= 1);
                e_done    = (n_int <= 1);
            end
        end
        e_busy  = ex_active;
        e_stall = r ? 6'd0 : ex_active ? 6'b001111 : sid ? 6'b000111 : 6'd0;
`ifdef BRANCH_DELAY_SLOT_EN
        e_flush = 1'b0;
`else
        e_flush = !r && br && !e_stall[2];
`endif
        check_val("stall", {26'd0, stall}, {26'd0, e_stall});
        check_val("flush_ifid", {31'd0, flush_ifid}, {31'd0, e_flush});
        check_val("ex_busy", {31'd0, ex_busy}, {31'd0, e_busy});
        check_val("ex_done", {31'd0, ex_done}, {31'd0, e_done});
        check_val("stall_cycles", stall_cycles, m_count[31:0]);
        // advance model
        if (r) begin
            m_rem   = 0;
            m_count = 0;
        end else begin
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (st && n_int >= 1) m_rem = n_int - 1;
            if (clr) m_count = 0;
            else if (e_stall[0] && m_count < 64'hFFFF_FFFF) m_count = m_count + 1;
        end
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b0; ex_mc_start = 1'b0; ex_mc_cycles = 5'd0;
        branch_flag = 1'b0; perf_clr = 1'b0;
        @(posedge clk);
        #1;
        // reset with busy inputs: outputs must stay 0
        step(1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2);

        // N = 5 from IDLE: five EX stall cycles, done in the fifth
        step(1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        idle(6);
        check_val("count_after_n5", stall_cycles, 32'd5);

        // ID hazard for three cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2);

        // ID hazard during an N = 4 operation, held beyond it
        step(1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(1);

        // branch with no stall, then with ID stalled, then during EX stall
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(1);

        // reset in the third cycle of an N = 10 operation
        step(1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check_val("count_after_rst", stall_cycles, 32'd0);
        idle(3);

        // N = 0 and N = 1, back-to-back, then perf_clr while stalling
        step(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        check_val("count_after_clr", stall_cycles, 32'd0);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] n;
            n = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 n,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-003 The block SHALL have port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port `stallreq_id`: input, 1 bit, ID-stage operand hazard, stall front end this cycle.
REQ-005 The block SHALL have port `ex_mc_start`: input, 1 bit, EX begins a multi-cycle operation this cycle.
REQ-006 The block SHALL have port `ex_mc_cycles`: input, 5 bits, length N of that operation in cycles, sampled with `ex_mc_start`.
REQ-007 The block SHALL have port `branch_flag`: input, 1 bit, ID resolved a taken jump/branch this cycle.
REQ-008 The block SHALL have port `perf_clr`: input, 1 bit, clears the stall-cycle counter.
REQ-009 The block SHALL have port `stall`: output, 6 bits; bit0 = PC, bit1 = IF, bit2 = ID, bit3 = EX, bit4 = MEM, bit5 = WB; 1 = hold.
REQ-010 The block SHALL have port `flush_ifid`: output, 1 bit; 1 = load a NOP into the IF/ID register at this edge.
REQ-011 The block SHALL have port `ex_busy`: output, 1 bit; high while a multi-cycle EX operation is in progress.
REQ-012 The block SHALL have port `ex_done`: output, 1 bit; one-cycle pulse in the final cycle of a multi-cycle operation.
REQ-013 The block SHALL have port `stall_cycles`: output, 32 bits; count of cycles with `stall[0]`=1.

Function
REQ-014 The FSM SHALL have two states, IDLE and EXBUSY, and a 5-bit down-counter `cnt`.
REQ-015 In IDLE, when `ex_mc_start`=1 and N≥2, the FSM SHALL move to EXBUSY and load `cnt`=N-2.
REQ-016 In IDLE, when `ex_mc_start`=1 and N≤1, the FSM SHALL stay in IDLE.
  - N=1: `stall`=6'b001111 and `ex_done`=1 in the start cycle.
  - N=0: `ex_done`=1 in the start cycle, no stall.
REQ-017 In EXBUSY, `cnt` SHALL decrement each cycle; when `cnt`=0, `ex_done`=1 and the next state is IDLE.
REQ-018 `ex_mc_start` SHALL be ignored while in EXBUSY.
REQ-019 The EX stall SHALL be `stall`=6'b001111 in the start cycle (N≥1) and in every EXBUSY cycle, i.e. N cycles total; `ex_busy` equals the same condition.
REQ-020 When the EX stall is not active and `stallreq_id`=1, `stall` SHALL be 6'b000111.
REQ-021 Otherwise `stall` SHALL be 6'b000000.
REQ-022 Priority SHALL be: EX stall > ID stall > branch.
REQ-023 `stall` and `ex_done` SHALL be combinational from state, `cnt` and the current-cycle inputs; there is no added latency.
REQ-024 A branch SHALL be accepted only when `branch_flag`=1 and `stall[2]`=0.
  - While ID is stalled, `branch_flag` is ignored.
  - ID holds the branch, so it is re-presented until accepted.
REQ-025 `stall_cycles` SHALL increment by 1 at each edge where `stall[0]`=1.
  - It saturates at 32'hFFFFFFFF.
  - `perf_clr`=1 loads 0, taking priority over the increment.

Reset
REQ-026 On `rst`=1 at a clock edge, the block SHALL set state to IDLE, `cnt` to 0 and `stall_cycles` to 0.
REQ-027 While `rst`=1, `stall`, `flush_ifid`, `ex_busy` and `ex_done` SHALL be 0 regardless of inputs.
REQ-028 A reset asserted mid-EXBUSY SHALL abort the operation, with no `ex_done` pulse, and return to IDLE at that edge.

Configuration
REQ-029 The macro `BRANCH_DELAY_SLOT_EN` SHALL select branch handling.
  - Defined: an accepted branch does not flush, so the delay-slot instruction executes, and `flush_ifid` is constant 0.
  - Undefined: `flush_ifid`=1, combinational, in each cycle a branch is accepted; otherwise 0.

Verification
REQ-030 The bench SHALL cover: `ex_mc_start`=1, N=5 in IDLE -> `stall`=6'b001111 for exactly 5 cycles, `ex_done` only in cycle 5, `stall_cycles` +5.
REQ-031 The bench SHALL cover: `stallreq_id`=1 for 3 cycles with no EX operation -> `stall`=6'b000111 for those 3 cycles, then 0.
REQ-032 The bench SHALL cover: `stallreq_id`=1 during an EXBUSY with N=4 -> `stall`=6'b001111 throughout, then 6'b000111 while `stallreq_id` stays high.
REQ-033 The bench SHALL cover: `branch_flag`=1 with `stall`=0, macro undefined -> `flush_ifid`=1 for one cycle; same stimulus with `stallreq_id`=1 -> `flush_ifid`=0.
REQ-034 The bench SHALL cover: `rst`=1 in the 3rd cycle of an N=10 operation -> next cycle IDLE, `stall`=0, no `ex_done`, `stall_cycles`=0.
REQ-035 The bench SHALL cover: N=0 and N=1 starts -> `ex_done` in the start cycle; stall 0 cycles for N=0 and 1 cycle for N=1; `perf_clr` with `stall[0]`=1 at the same edge -> `stall_cycles`=0.
